demux1to16_collector: RTL and testbench

Serial-to-parallel collector that steers one input bit per cycle into one of 16 register positions selected by a 4-bit address. It is the write-side counterpart of the 16-to-1 bit selectors in the datapath. A 16-bit word read out bit-by-bit through `sel` can be rebuilt here in either explicitly addressed or auto-incrementing order. Downstream logic consumes the assembled word on `J` once `full` or `frame_done` indicates completion.

---
 rtl/demux1to16_collector.sv | 95 +++++++++
 tb/tb_demux1to16_collector.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/demux1to16_collector.sv
// Serial-to-parallel collector: steers one bit per cycle into J[0:15], either by
// explicit address or through an auto-incrementing pointer, and tracks completion.
module demux1to16_collector (
    input  logic        clk,
    input  logic        rst,
    input  logic        din,
    input  logic        din_valid,
    input  logic        mode,
    input  logic [3:0]  sel,
    input  logic        sel_load,
    input  logic        clear,
    output logic [0:15] J,
    output logic [3:0]  ptr,
    output logic        full,
    output logic        frame_done,
    output logic [1:0]  fsm_state
);

    // Handshake: the block is always ready; din is captured on every rising
    // edge where din_valid is high, and there is no backpressure.

    typedef enum logic [1:0] {
        EMPTY   = 2'd0,
        PARTIAL = 2'd1,
        FULL    = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] wmask, wmask_d;
    logic [0:15] j_d;
    logic [3:0]  ptr_d;
    logic [3:0]  addr;
    logic        pulse_d;

    // Sequential mode follows ptr unless a start address is being loaded.
    assign addr = (mode && !sel_load) ? ptr : sel;

    always_comb begin
        j_d     = J;
        wmask_d = wmask;
        ptr_d   = ptr;
        pulse_d = 1'b0;
        if (din_valid) begin
            j_d[addr]     = din;
            wmask_d[addr] = 1'b1;
            if (mode) begin
                ptr_d   = addr + 4'd1;
                pulse_d = (addr == 4'd15);
            end else if (sel_load) begin
                ptr_d = sel;
            end
        end else if (sel_load) begin
            ptr_d = sel;
        end
    end

    // Next state is judged on the mask as it will be after this edge.
    always_comb begin
        state_d = state_q;
        case (state_q)
            EMPTY: begin
                if (&wmask_d)
                    state_d = FULL;
                else if (|wmask_d)
                    state_d = PARTIAL;
            end
            PARTIAL: begin
                if (&wmask_d)
                    state_d = FULL;
            end
            FULL:    state_d = FULL;
            default: state_d = EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            J          <= '0;
            wmask      <= '0;
            ptr        <= '0;
            frame_done <= 1'b0;
            state_q    <= EMPTY;
        end else begin
            J          <= j_d;
            wmask      <= wmask_d;
            ptr        <= ptr_d;
            frame_done <= pulse_d;
            state_q    <= state_d;
        end
    end

    assign full      = (state_q == FULL);
    assign fsm_state = state_q;

endmodule

// File: tb/tb_demux1to16_collector.sv
// Directed bench for demux1to16_collector: a per-cycle model of the written
// positions plus hand-computed expectations at the end of each scenario.
module tb_demux1to16_collector;

    logic        clk = 1'b0;
    logic        rst, din, din_valid, mode, sel_load, clear;
    logic [3:0]  sel;
    logic [0:15] J;
    logic [3:0]  ptr;
    logic        full, frame_done;
    logic [1:0]  fsm_state;

    demux1to16_collector dut (
        .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .mode(mode),
        .sel(sel), .sel_load(sel_load), .clear(clear), .J(J), .ptr(ptr),
        .full(full), .frame_done(frame_done), .fsm_state(fsm_state)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int fd_seen  = 0;
    bit chk_en   = 1'b0;

    // Model: contents, set of written positions, pointer, pulse.
    logic [0:15] exp_j;
    bit          written [16];
    logic [3:0]  exp_ptr;
    logic        exp_fd, exp_full;
    logic [1:0]  exp_state;

    task automatic check16(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    task automatic model_update();
        int cnt;
        int a;
        if (rst || clear) begin
            exp_j = '0;
            foreach (written[i]) written[i] = 1'b0;
            exp_ptr = 4'd0;
            exp_fd  = 1'b0;
        end else begin
            exp_fd = 1'b0;
            if (din_valid) begin
                a = (mode && !sel_load) ? int'(exp_ptr) : int'(sel);
                exp_j[a]   = din;
                written[a] = 1'b1;
                if (mode) begin
                    exp_fd  = (a == 15);
                    exp_ptr = 4'((a + 1) % 16);
                end else if (sel_load) begin
                    exp_ptr = sel;
                end
            end else if (sel_load) begin
                exp_ptr = sel;
            end
        end
        cnt = 0;
        foreach (written[i]) if (written[i]) cnt++;
        exp_full  = (cnt == 16);
        exp_state = (cnt == 0) ? 2'd0 : (cnt == 16) ? 2'd2 : 2'd1;
        chk_en = 1'b1;
    endtask

    task automatic step(input logic r, input logic c, input logic v, input logic d,
                        input logic m, input logic sl, input logic [3:0] s);
        rst = r; clear = c; din_valid = v; din = d; mode = m; sel_load = sl; sel = s;
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic idle();
        step(0, 0, 0, 0, 0, 0, 4'd0);
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check16("j", J, exp_j);
            check16("ptr", {12'd0, ptr}, {12'd0, exp_ptr});
            check16("full", {15'd0, full}, {15'd0, exp_full});
            check16("frame_done", {15'd0, frame_done}, {15'd0, exp_fd});
            check16("state", {14'd0, fsm_state}, {14'd0, exp_state});
            if (frame_done === 1'b1) fd_seen++;
        end
    end

    logic [15:0] pat;
    int          fd_mark;

    initial begin
        rst = 1; clear = 0; din_valid = 0; din = 0; mode = 0; sel_load = 0; sel = 0;

        // Reset held two cycles with a write pending.
        step(1, 0, 1, 1, 1, 0, 4'd0);
        step(1, 0, 1, 1, 1, 0, 4'd0);
        idle();
        check16("reset_j", J, 16'h0000);
        check16("reset_ptr", {12'd0, ptr}, 16'd0);

        // Sequential fill.
        pat = 16'b1011_0001_1111_0000;
        fd_mark = fd_seen;
        for (int i = 0; i < 16; i++) step(0, 0, 1, pat[15 - i], 1, 0, 4'd0);
        check16("seq_j", J, 16'b1011_0001_1111_0000);
        check16("seq_ptr", {12'd0, ptr}, 16'd0);
        check16("seq_fd_on_wrap", {15'd0, frame_done}, 16'd1);
        check16("seq_full_with_wrap", {15'd0, full}, 16'd1);
        idle();
        check16("seq_fd_one_cycle", {15'd0, frame_done}, 16'd0);
        check16("seq_fd_count", 16'(fd_seen - fd_mark), 16'd1);

        // Clear priority over write and sel_load.
        step(0, 1, 1, 1, 1, 1, 4'd5);
        check16("clr_j", J, 16'h0000);
        check16("clr_ptr", {12'd0, ptr}, 16'd0);
        check16("clr_full", {15'd0, full}, 16'd0);
        check16("clr_state", {14'd0, fsm_state}, 16'd0);

        // Addressed writes.
        fd_mark = fd_seen;
        step(0, 0, 1, 1, 0, 0, 4'd15);
        step(0, 0, 1, 1, 0, 0, 4'd3);
        step(0, 0, 1, 1, 0, 0, 4'd8);
        idle();
        check16("addr_j", J, 16'b0001_0000_1000_0001);
        check16("addr_full", {15'd0, full}, 16'd0);
        check16("addr_ptr", {12'd0, ptr}, 16'd0);
        check16("addr_state", {14'd0, fsm_state}, 16'd1);
        check16("addr_no_fd", 16'(fd_seen - fd_mark), 16'd0);

        // Overwrite an addressed bit, then sel_load alone.
        step(0, 0, 1, 0, 0, 0, 4'd8);
        step(0, 0, 0, 1, 1, 1, 4'd9);
        check16("ovw_j", J, 16'b0001_0000_0000_0001);
        check16("load_only_ptr", {12'd0, ptr}, 16'd9);

        // Start-address load.
        step(0, 1, 0, 0, 0, 0, 4'd0);
        step(0, 0, 1, 1, 1, 1, 4'd14);
        step(0, 0, 1, 1, 1, 0, 4'd0);
        check16("load_fd_after_15", {15'd0, frame_done}, 16'd1);
        step(0, 0, 1, 1, 1, 0, 4'd0);
        check16("load_j", J, 16'b1000_0000_0000_0011);
        check16("load_ptr", {12'd0, ptr}, 16'd1);

        // Mode switch mid-stream: addressed write does not move ptr.
        step(0, 0, 1, 1, 0, 0, 4'd6);
        check16("mix_ptr", {12'd0, ptr}, 16'd1);

        // Reset mid-frame, then a full all-ones frame.
        step(0, 1, 0, 0, 0, 0, 4'd0);
        for (int i = 0; i < 7; i++) step(0, 0, 1, 1, 1, 0, 4'd0);
        step(1, 0, 0, 0, 0, 0, 4'd0);
        check16("rst_mid_j", J, 16'h0000);
        fd_mark = fd_seen;
        for (int i = 0; i < 16; i++) step(0, 0, 1, 1, 1, 0, 4'd0);
        idle();
        check16("rfill_j", J, 16'hFFFF);
        check16("rfill_full", {15'd0, full}, 16'd1);
        check16("rfill_fd_count", 16'(fd_seen - fd_mark), 16'd1);

        // FULL persists across further writes.
        step(0, 0, 1, 0, 0, 0, 4'd2);
        check16("full_stays", {15'd0, full}, 16'd1);
        idle();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
